hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 22 ++
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard_counter.sv | 22 ++
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: the hazard_cause values and
// the state types of the multi-cycle and control FSMs.
package hazard_scoreboard_pkg;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'd0,
      CAUSE_CTRL   = 2'd1,
      CAUSE_STRUCT = 2'd2,
      CAUSE_DATA   = 2'd3
   } hazard_cause_e;

   typedef enum logic {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_e;

   typedef enum logic {
      RUN       = 1'b0,
      CTRL_WAIT = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and pipeline stall controls exchanged with the hazard scoreboard.
interface hazard_scoreboard_if #(
   parameter int RW = 4,
   parameter int LW = 4
);
   import hazard_scoreboard_pkg::*;

   logic          id_valid;
   logic [RW-1:0] id_rs1;
   logic [RW-1:0] id_rs2;
   logic          id_rs1_used;
   logic          id_rs2_used;
   logic [RW-1:0] id_rd;
   logic          id_rd_we;
   logic          id_is_ctrl;
   logic          id_is_mc;
   logic [LW-1:0] id_mc_lat;
   logic          ex_ctrl_resolved;
   logic          if_stall;
   logic          id_stall;
   logic          ex_bubble;
   hazard_cause_e hazard_cause;
   logic          mc_busy;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
             id_is_ctrl, id_is_mc, id_mc_lat, ex_ctrl_resolved,
      input  if_stall, id_stall, ex_bubble, hazard_cause, mc_busy
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
             id_is_ctrl, id_is_mc, id_mc_lat, ex_ctrl_resolved,
      output if_stall, id_stall, ex_bubble, hazard_cause, mc_busy
   );

endinterface

// File: rtl/hazard_scoreboard_counter.sv
// Per-register busy countdown: a load wins over the decrement, and the count
// rests at zero once the result has been written back.
module hazard_sb_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - CW'(1);
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard unit: register scoreboard, multi-cycle unit
// occupancy and branch wait, producing same-cycle stall/bubble controls.
module hazard_scoreboard #(
   parameter int NREG       = 16,
   parameter int PIPE_DEPTH = 3,
   parameter int MC_MAX_LAT = 8,
   parameter int FWD_EN     = 0
) (
   input logic               clk,
   input logic               rst_n,
   hazard_scoreboard_if.slave sb
);
   import hazard_scoreboard_pkg::*;

   localparam int RW = $clog2(NREG);
   localparam int CW = $clog2(PIPE_DEPTH + MC_MAX_LAT + 1);
   localparam int LW = $clog2(MC_MAX_LAT + 1);

   logic [NREG-1:0][CW-1:0] cnt;
   logic [LW-1:0]           lat_eff;
   logic [CW-1:0]           load_val;
   logic                    issue;
   logic                    data_hz;
   logic                    struct_hz;
   logic                    ctrl_hz;
   logic                    ctrl_wait_open;
   logic                    id_stall_c;
   mc_state_e               mc_state;
   mc_state_e               mc_next;
   logic [LW-1:0]           mc_cnt;
   logic [LW-1:0]           mc_cnt_next;
   ctrl_state_e             ctrl_state;
   ctrl_state_e             ctrl_next;

   function automatic logic src_ready(input logic [CW-1:0] c);
      if (FWD_EN != 0)
         return c <= CW'(1);
      else
         return c == '0;
   endfunction

   // A multi-cycle result lands L-1 cycles after a plain one; L is clamped to 1..MC_MAX_LAT.
   always_comb begin
      lat_eff = sb.id_mc_lat;
      if (sb.id_mc_lat == '0)
         lat_eff = LW'(1);
      else if (sb.id_mc_lat > LW'(MC_MAX_LAT))
         lat_eff = LW'(MC_MAX_LAT);
      load_val = sb.id_is_mc ? CW'(PIPE_DEPTH) + CW'(lat_eff) - CW'(1) : CW'(PIPE_DEPTH);
   end

   assign cnt[0] = '0;

   for (genvar g = 1; g < NREG; g++) begin : g_cnt
      hazard_sb_counter #(.CW(CW)) u_cnt (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (issue && sb.id_rd_we && (sb.id_rd == RW'(g))),
         .load_val (load_val),
         .cnt      (cnt[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mc_state   <= MC_IDLE;
         mc_cnt     <= '0;
         ctrl_state <= RUN;
      end else begin
         mc_state   <= mc_next;
         mc_cnt     <= mc_cnt_next;
         ctrl_state <= ctrl_next;
      end
   end

   always_comb begin
      mc_next     = mc_state;
      mc_cnt_next = mc_cnt;
      ctrl_next   = ctrl_state;
      case (mc_state)
         MC_IDLE: if (issue && sb.id_is_mc) begin
            mc_next     = MC_BUSY;
            mc_cnt_next = lat_eff;
         end
         MC_BUSY: begin
            mc_cnt_next = mc_cnt - LW'(1);
            if (mc_cnt <= LW'(1)) begin
               mc_next     = MC_IDLE;
               mc_cnt_next = '0;
            end
         end
         default: mc_next = MC_IDLE;
      endcase
      case (ctrl_state)
         RUN:       if (issue && sb.id_is_ctrl) ctrl_next = CTRL_WAIT;
         CTRL_WAIT: if (sb.ex_ctrl_resolved) ctrl_next = RUN;
         default:   ctrl_next = RUN;
      endcase
   end

   // Once EX resolves, the wait term drops in that same cycle for both IF and the bubble.
   always_comb begin
      data_hz = sb.id_valid &&
                ((sb.id_rs1_used && !src_ready(cnt[sb.id_rs1])) ||
                 (sb.id_rs2_used && !src_ready(cnt[sb.id_rs2])) ||
                 (sb.id_rd_we && (sb.id_rd != '0) && (cnt[sb.id_rd] != '0)));
      struct_hz      = sb.id_valid && sb.id_is_mc && (mc_state == MC_BUSY);
      ctrl_wait_open = (ctrl_state == CTRL_WAIT) && !sb.ex_ctrl_resolved;
      ctrl_hz        = (sb.id_valid && sb.id_is_ctrl) || ctrl_wait_open;
      id_stall_c     = data_hz || struct_hz;
      issue          = sb.id_valid && !id_stall_c;
   end

   assign sb.id_stall     = id_stall_c;
   assign sb.if_stall     = id_stall_c || ctrl_hz;
   assign sb.ex_bubble    = (sb.id_valid && id_stall_c) || ctrl_wait_open;
   assign sb.mc_busy      = (mc_state == MC_BUSY);
   assign sb.hazard_cause = data_hz   ? CAUSE_DATA   :
                            struct_hz ? CAUSE_STRUCT :
                            ctrl_hz   ? CAUSE_CTRL   : CAUSE_NONE;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one instance without bypass (dut0)
// and one with bypass (dut1) see identical ID-stage stimulus.
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.RW(4), .LW(4)) bus0 ();
   hazard_scoreboard_if #(.RW(4), .LW(4)) bus1 ();

   hazard_scoreboard #(.NREG(16), .PIPE_DEPTH(3), .MC_MAX_LAT(8), .FWD_EN(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (bus0)
   );

   hazard_scoreboard #(.NREG(16), .PIPE_DEPTH(3), .MC_MAX_LAT(8), .FWD_EN(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (bus1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic check0(input string tag, input int ifs, input int ids, input int bub, input int cause, input int busy);
      checkOutput({"dut0.", tag, ".if_stall"},  32'(bus0.if_stall),     32'(ifs));
      checkOutput({"dut0.", tag, ".id_stall"},  32'(bus0.id_stall),     32'(ids));
      checkOutput({"dut0.", tag, ".ex_bubble"}, 32'(bus0.ex_bubble),    32'(bub));
      checkOutput({"dut0.", tag, ".cause"},     32'(bus0.hazard_cause), 32'(cause));
      checkOutput({"dut0.", tag, ".mc_busy"},   32'(bus0.mc_busy),      32'(busy));
   endtask

   task automatic check1(input string tag, input int ifs, input int ids, input int bub, input int cause, input int busy);
      checkOutput({"dut1.", tag, ".if_stall"},  32'(bus1.if_stall),     32'(ifs));
      checkOutput({"dut1.", tag, ".id_stall"},  32'(bus1.id_stall),     32'(ids));
      checkOutput({"dut1.", tag, ".ex_bubble"}, 32'(bus1.ex_bubble),    32'(bub));
      checkOutput({"dut1.", tag, ".cause"},     32'(bus1.hazard_cause), 32'(cause));
      checkOutput({"dut1.", tag, ".mc_busy"},   32'(bus1.mc_busy),      32'(busy));
   endtask

   task automatic applyStimulus(input logic valid, input int rs1, input logic rs1_used,
                                input int rs2, input logic rs2_used, input int rd, input logic rd_we,
                                input logic is_ctrl, input logic is_mc, input int mc_lat,
                                input logic resolved);
      bus0.id_valid = valid;        bus1.id_valid = valid;
      bus0.id_rs1 = 4'(rs1);        bus1.id_rs1 = 4'(rs1);
      bus0.id_rs1_used = rs1_used;  bus1.id_rs1_used = rs1_used;
      bus0.id_rs2 = 4'(rs2);        bus1.id_rs2 = 4'(rs2);
      bus0.id_rs2_used = rs2_used;  bus1.id_rs2_used = rs2_used;
      bus0.id_rd = 4'(rd);          bus1.id_rd = 4'(rd);
      bus0.id_rd_we = rd_we;        bus1.id_rd_we = rd_we;
      bus0.id_is_ctrl = is_ctrl;    bus1.id_is_ctrl = is_ctrl;
      bus0.id_is_mc = is_mc;        bus1.id_is_mc = is_mc;
      bus0.id_mc_lat = 4'(mc_lat);  bus1.id_mc_lat = 4'(mc_lat);
      bus0.ex_ctrl_resolved = resolved;
      bus1.ex_ctrl_resolved = resolved;
   endtask

   task automatic idle(input logic resolved);
      applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, resolved);
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle(1'b0);
      #3;
      check0("reset", 0, 0, 0, 0, 0);
      check1("reset", 0, 0, 0, 0, 0);
      #4 rst_n = 1'b1;
      #1;
      check0("post_reset", 0, 0, 0, 0, 0);

      // RAW on r3: producer at c0, consumer held in ID from c1.
      next_cycle(); applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0); settle();
      check0("raw.c0", 0, 0, 0, 0, 0);
      next_cycle(); applyStimulus(1'b1, 3, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0); settle();
      check0("raw.c1", 1, 1, 1, 3, 0);
      check1("raw.c1", 1, 1, 1, 3, 0);
      next_cycle(); settle();
      check0("raw.c2", 1, 1, 1, 3, 0);
      check1("raw.c2", 1, 1, 1, 3, 0);
      next_cycle(); settle();
      check0("raw.c3", 1, 1, 1, 3, 0);
      check1("raw.c3", 0, 0, 0, 0, 0);
      next_cycle(); settle();
      check0("raw.c4", 0, 0, 0, 0, 0);
      next_cycle(); idle(1'b0);
      next_cycle(); idle(1'b0);

      // Multi-cycle op L=4 writing r5, second mc op waits on the unit.
      next_cycle(); applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b1, 4, 1'b0); settle();
      check0("mc.c0", 0, 0, 0, 0, 0);
      next_cycle(); applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0, 1'b1, 1, 1'b0); settle();
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) begin next_cycle(); settle(); end
         check0($sformatf("mc.c%0d", k), 1, 1, 1, 2, 1);
         check1($sformatf("mc.c%0d", k), 1, 1, 1, 2, 1);
      end
      next_cycle(); settle();
      check0("mc.c5", 0, 0, 0, 0, 0);
      // r5 was loaded with 6 at c0, so it reads 1 at c6 and 0 at c7.
      next_cycle(); applyStimulus(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0); settle();
      check0("mc.r5.c6", 1, 1, 1, 3, 1);
      check1("mc.r5.c6", 0, 0, 0, 0, 1);
      next_cycle(); settle();
      check0("mc.r5.c7", 0, 0, 0, 0, 0);

      // Latency 0 behaves as 1: busy for exactly one cycle.
      next_cycle(); applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0); settle();
      check0("lat0.issue", 0, 0, 0, 0, 0);
      next_cycle(); idle(1'b0); settle();
      check0("lat0.busy", 0, 0, 0, 0, 1);
      next_cycle(); settle();
      check0("lat0.done", 0, 0, 0, 0, 0);

      // Latency 12 clamps to 8: busy eight cycles, r9 loaded with 10.
      next_cycle(); applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 1'b1, 12, 1'b0); settle();
      check0("clamp.issue", 0, 0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         next_cycle(); idle(1'b0); settle();
         checkOutput($sformatf("dut0.clamp.busy%0d", k), 32'(bus0.mc_busy), 32'd1);
      end
      next_cycle(); settle();
      checkOutput("dut0.clamp.idle", 32'(bus0.mc_busy), 32'd0);
      next_cycle(); applyStimulus(1'b1, 0, 1'b0, 9, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0); settle();
      check0("clamp.r9.cnt1", 1, 1, 1, 3, 0);
      check1("clamp.r9.cnt1", 0, 0, 0, 0, 0);
      next_cycle(); settle();
      check0("clamp.r9.cnt0", 0, 0, 0, 0, 0);

      // Branch (writing r0) at c0, resolved at c3.
      next_cycle(); applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0); settle();
      check0("br.c0", 1, 0, 0, 1, 0);
      check1("br.c0", 1, 0, 0, 1, 0);
      next_cycle(); idle(1'b0); settle();
      check0("br.c1", 1, 0, 1, 1, 0);
      next_cycle(); settle();
      check0("br.c2", 1, 0, 1, 1, 0);
      next_cycle(); idle(1'b1); settle();
      checkOutput("dut0.br.c3.if_stall", 32'(bus0.if_stall), 32'd0);
      checkOutput("dut0.br.c3.id_stall", 32'(bus0.id_stall), 32'd0);
      next_cycle(); applyStimulus(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0); settle();
      check0("br.c4.r0", 0, 0, 0, 0, 0);
      check1("br.c4.r0", 0, 0, 0, 0, 0);
      // Resolved while still in RUN must not cancel the wait that follows.
      next_cycle(); applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b1); settle();
      check0("br2.c0", 1, 0, 0, 1, 0);
      next_cycle(); idle(1'b0); settle();
      check0("br2.c1", 1, 0, 1, 1, 0);
      next_cycle(); idle(1'b1); settle();
      checkOutput("dut0.br2.c2.if_stall", 32'(bus0.if_stall), 32'd0);
      next_cycle(); idle(1'b0); settle();
      check0("br2.c3", 0, 0, 0, 0, 0);

      // Reset mid CTRL_WAIT with r7 busy and the mc unit occupied.
      next_cycle(); applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1, 1'b1, 8, 1'b0); settle();
      check0("rst.c0", 1, 0, 0, 1, 0);
      next_cycle(); idle(1'b0); settle();
      check0("rst.c1", 1, 0, 1, 1, 1);
      rst_n = 1'b0;
      #1;
      check0("rst.async", 0, 0, 0, 0, 0);
      check1("rst.async", 0, 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      next_cycle(); applyStimulus(1'b1, 7, 1'b1, 7, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0); settle();
      check0("rst.r7", 0, 0, 0, 0, 0);
      check1("rst.r7", 0, 0, 0, 0, 0);
      next_cycle(); idle(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
